// File: rtl/branch_pkg.sv
// Shared constants for the branch/PC unit: flag bit positions, condition codes,
// transfer modes and the condition evaluator.
package branch_pkg;

  localparam int unsigned FLAG_W = 4;

  localparam logic [1:0] FLAG_Z = 2'd0;
  localparam logic [1:0] FLAG_S = 2'd1;
  localparam logic [1:0] FLAG_C = 2'd2;
  localparam logic [1:0] FLAG_V = 2'd3;

  localparam logic [3:0] COND_AL = 4'd0;
  localparam logic [3:0] COND_EQ = 4'd1;
  localparam logic [3:0] COND_NE = 4'd2;
  localparam logic [3:0] COND_CS = 4'd3;
  localparam logic [3:0] COND_CC = 4'd4;
  localparam logic [3:0] COND_MI = 4'd5;
  localparam logic [3:0] COND_PL = 4'd6;
  localparam logic [3:0] COND_VS = 4'd7;
  localparam logic [3:0] COND_VC = 4'd8;
  localparam logic [3:0] COND_HI = 4'd9;
  localparam logic [3:0] COND_LS = 4'd10;
  localparam logic [3:0] COND_GE = 4'd11;
  localparam logic [3:0] COND_LT = 4'd12;
  localparam logic [3:0] COND_GT = 4'd13;
  localparam logic [3:0] COND_LE = 4'd14;
  localparam logic [3:0] COND_NV = 4'd15;

  typedef enum logic [1:0] {
    BR_ABS  = 2'b00,
    BR_REL  = 2'b01,
    BR_CALL = 2'b10,
    BR_RET  = 2'b11
  } branch_mode_e;

  function automatic logic cond_eval(input logic [FLAG_W-1:0] flags, input logic [3:0] code);
    logic z, s, c, v, r;
    z = flags[FLAG_Z];
    s = flags[FLAG_S];
    c = flags[FLAG_C];
    v = flags[FLAG_V];
    case (code)
      COND_AL: r = 1'b1;
      COND_EQ: r = z;
      COND_NE: r = !z;
      COND_CS: r = c;
      COND_CC: r = !c;
      COND_MI: r = s;
      COND_PL: r = !s;
      COND_VS: r = v;
      COND_VC: r = !v;
      COND_HI: r = c & !z;
      COND_LS: r = !c | z;
      COND_GE: r = (s == v);
      COND_LT: r = (s != v);
      COND_GT: r = !z & (s == v);
      COND_LE: r = z | (s != v);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/branch_unit_if.sv
// Control/flag/PC bundle between the control unit (master) and the branch unit (slave).
interface branch_unit_if #(parameter int unsigned ADDR_W = 32);

  logic              pc_en;
  logic [ADDR_W-1:0] jump_addr;
  logic              zero_flag;
  logic              sign_flag;
  logic              carry_flag;
  logic              overflow_flag;
  logic              flag_we;
  logic [3:0]        FlagControl;
  logic              BranchControl;
  logic [1:0]        branch_mode;
  logic [ADDR_W-1:0] program_counter_out;
  logic              branch_taken;
  logic              ras_empty;
  logic              ras_overflow;
  logic              ras_underflow;

  modport master (
    output pc_en, jump_addr, zero_flag, sign_flag, carry_flag, overflow_flag,
           flag_we, FlagControl, BranchControl, branch_mode,
    input  program_counter_out, branch_taken, ras_empty, ras_overflow, ras_underflow
  );

  modport slave (
    input  pc_en, jump_addr, zero_flag, sign_flag, carry_flag, overflow_flag,
           flag_we, FlagControl, BranchControl, branch_mode,
    output program_counter_out, branch_taken, ras_empty, ras_overflow, ras_underflow
  );

endinterface

// File: rtl/branch_unit_return_stack.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module return_stack #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] pop_data,
  output logic              empty,
  output logic              overflow
);

  localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

  logic [ADDR_W-1:0] mem [RAS_DEPTH];
  logic [PTR_W-1:0]  top_q;
  logic [PTR_W-1:0]  wr_ptr_c;
  logic [CNT_W-1:0]  cnt_q;
  logic              full_c;
  logic              ovf_q;

  assign wr_ptr_c = top_q + PTR_W'(1);
  assign full_c   = (cnt_q == CNT_W'(RAS_DEPTH));

  // top_q always indexes the most recent entry
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      top_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (push) begin
      top_q <= wr_ptr_c;
      if (full_c) ovf_q <= 1'b1;
      else        cnt_q <= cnt_q + CNT_W'(1);
    end else if (pop) begin
      top_q <= top_q - PTR_W'(1);
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_c] <= push_data;
  end

  assign pop_data = mem[top_q];
  assign empty    = (cnt_q == '0);
  assign overflow = ovf_q;

endmodule

// File: rtl/branch_unit.sv
// PC register, flag register and conditional transfer logic for the single-cycle CPU.
// Return-address stack built only when BRANCH_RAS_EN is defined.
module branch_unit #(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       PC_STEP   = 4,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int unsigned       RAS_DEPTH = 4
) (
  input logic        clk,
  input logic        reset,
  branch_unit_if.slave bus
);
  import branch_pkg::*;

  if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("branch_unit: RAS_DEPTH must be a power of two >= 2");
  end

  logic [FLAG_W-1:0] flag_q, flag_in_c, flag_eff_c;
  logic [ADDR_W-1:0] pc_q, seq_c, next_pc_c;
  logic              take_c, redirect_c, taken_q;
  branch_mode_e      mode_c;

`ifdef BRANCH_RAS_EN
  logic              push_c, pop_c, underflow_c, underflow_q;
  logic              ras_empty_c, ras_overflow_c;
  logic [ADDR_W-1:0] pop_data_c;
`endif

  always_comb begin
    flag_in_c         = '0;
    flag_in_c[FLAG_Z] = bus.zero_flag;
    flag_in_c[FLAG_S] = bus.sign_flag;
    flag_in_c[FLAG_C] = bus.carry_flag;
    flag_in_c[FLAG_V] = bus.overflow_flag;
  end

  // incoming flags bypass the register on the cycle they are written
  assign flag_eff_c = bus.flag_we ? flag_in_c : flag_q;
  assign take_c     = bus.pc_en & bus.BranchControl & cond_eval(flag_eff_c, bus.FlagControl);
  assign seq_c      = pc_q + ADDR_W'(PC_STEP);
  assign mode_c     = branch_mode_e'(bus.branch_mode);

  always_comb begin
    next_pc_c  = seq_c;
    redirect_c = 1'b0;
`ifdef BRANCH_RAS_EN
    push_c      = 1'b0;
    pop_c       = 1'b0;
    underflow_c = 1'b0;
`endif
    if (take_c) begin
      case (mode_c)
        BR_ABS: begin
          next_pc_c  = bus.jump_addr;
          redirect_c = 1'b1;
        end
        BR_REL: begin
          next_pc_c  = seq_c + bus.jump_addr;
          redirect_c = 1'b1;
        end
        BR_CALL: begin
          next_pc_c  = bus.jump_addr;
          redirect_c = 1'b1;
`ifdef BRANCH_RAS_EN
          push_c     = 1'b1;
`endif
        end
        BR_RET: begin
`ifdef BRANCH_RAS_EN
          // an empty-stack return falls through to the next instruction
          if (!ras_empty_c) begin
            next_pc_c  = pop_data_c;
            redirect_c = 1'b1;
            pop_c      = 1'b1;
          end else begin
            underflow_c = 1'b1;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      flag_q  <= '0;
      taken_q <= 1'b0;
    end else begin
      if (bus.flag_we) flag_q <= flag_in_c;
      if (bus.pc_en)   pc_q   <= next_pc_c;
      taken_q <= redirect_c;
    end
  end

  assign bus.program_counter_out = pc_q;
  assign bus.branch_taken        = taken_q;

`ifdef BRANCH_RAS_EN
  return_stack #(
    .ADDR_W    (ADDR_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (push_c),
    .pop       (pop_c),
    .push_data (seq_c),
    .pop_data  (pop_data_c),
    .empty     (ras_empty_c),
    .overflow  (ras_overflow_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) underflow_q <= 1'b0;
    else       underflow_q <= underflow_c;
  end

  assign bus.ras_empty     = ras_empty_c;
  assign bus.ras_overflow  = ras_overflow_c;
  assign bus.ras_underflow = underflow_q;
`else
  assign bus.ras_empty     = 1'b1;
  assign bus.ras_overflow  = 1'b0;
  assign bus.ras_underflow = 1'b0;
`endif

endmodule

// File: tb/tb_branch_unit.sv
// Directed self-checking bench for branch_unit; expectations follow BRANCH_RAS_EN.
module tb_branch_unit;
  import branch_pkg::*;

`ifdef BRANCH_RAS_EN
  localparam bit RAS = 1'b1;
`else
  localparam bit RAS = 1'b0;
`endif

  logic clk;
  logic reset;
  int unsigned n_vec;
  int unsigned n_err;

  branch_unit_if #(.ADDR_W(32)) bus ();

  branch_unit #(
    .ADDR_W    (32),
    .PC_STEP   (4),
    .RESET_PC  (32'h0),
    .RAS_DEPTH (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic bc, input logic [3:0] fc,
                       input logic [1:0] mode, input logic [31:0] ja);
    bus.pc_en         = en;
    bus.BranchControl = bc;
    bus.FlagControl   = fc;
    bus.branch_mode   = mode;
    bus.jump_addr     = ja;
  endtask

  task automatic set_flags(input logic we, input logic z, input logic s,
                           input logic c, input logic v);
    bus.flag_we       = we;
    bus.zero_flag     = z;
    bus.sign_flag     = s;
    bus.carry_flag    = c;
    bus.overflow_flag = v;
  endtask

  task automatic goto_addr(input logic [31:0] a);
    set_flags(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, COND_AL, BR_ABS, a);
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(1'b0, 1'b0, COND_AL, BR_ABS, 32'h0);
    set_flags(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #2;
    n_vec++;
    if (bus.program_counter_out !== 32'h0) begin
      n_err++; $display("FAIL reset_pc: got %h want %h", bus.program_counter_out, 32'h0);
    end
    n_vec++;
    if ({bus.branch_taken, bus.ras_empty, bus.ras_overflow, bus.ras_underflow} !== 4'b0100) begin
      n_err++; $display("FAIL reset_status: got %b want %b",
        {bus.branch_taken, bus.ras_empty, bus.ras_overflow, bus.ras_underflow}, 4'b0100);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    drive(1'b1, 1'b0, COND_AL, BR_ABS, 32'h0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_vec++;
      if (bus.program_counter_out !== 32'(4 * i)) begin
        n_err++; $display("FAIL seq_pc[%0d]: got %h want %h", i, bus.program_counter_out, 32'(4 * i));
      end
    end
  endtask

  // PC starts at 0x0C; register loaded with S=1 V=1 on the first row
  task automatic test_condition();
    logic [3:0]  fc  [6] = '{COND_LT, COND_GE, COND_NV, COND_GT, COND_LE, COND_AL};
    logic        bc  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] ja  [6] = '{32'd40, 32'd40, 32'h80, 32'h80, 32'h10, 32'h10};
    logic [31:0] epc [6] = '{32'h10, 32'h28, 32'h2C, 32'h80, 32'h84, 32'h88};
    logic        ebt [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      set_flags(i == 0, 1'b0, 1'b1, 1'b0, 1'b1);
      drive(1'b1, bc[i], fc[i], BR_ABS, ja[i]);
      tick();
      n_vec++;
      if (bus.program_counter_out !== epc[i] || bus.branch_taken !== ebt[i]) begin
        n_err++; $display("FAIL cond[%0d]: got pc=%h bt=%b want pc=%h bt=%b",
          i, bus.program_counter_out, bus.branch_taken, epc[i], ebt[i]);
      end
    end
  endtask

  // register holds Z=0 S=1 C=0 V=1 on entry
  task automatic test_bypass();
    logic        we  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic        z   [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic        c   [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [3:0]  fc  [4] = '{COND_EQ, COND_HI, COND_HI, COND_NE};
    logic [31:0] ja  [4] = '{32'h100, 32'h200, 32'h300, 32'h400};
    for (int i = 0; i < 4; i++) begin
      set_flags(we[i], z[i], 1'b0, c[i], 1'b0);
      drive(1'b1, 1'b1, fc[i], BR_ABS, ja[i]);
      tick();
      n_vec++;
      if (bus.program_counter_out !== ja[i] || bus.branch_taken !== 1'b1) begin
        n_err++; $display("FAIL bypass[%0d]: got pc=%h bt=%b want pc=%h bt=1",
          i, bus.program_counter_out, bus.branch_taken, ja[i]);
      end
    end
  endtask

  task automatic test_relative();
    logic [3:0]  fc  [3] = '{COND_AL, COND_AL, COND_NV};
    logic [31:0] ja  [3] = '{32'hFFFF_FFF8, 32'h10, 32'h10};
    logic [31:0] epc [3] = '{32'h1C, 32'h30, 32'h34};
    logic        ebt [3] = '{1'b1, 1'b1, 1'b0};
    goto_addr(32'h20);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, fc[i], BR_REL, ja[i]);
      tick();
      n_vec++;
      if (bus.program_counter_out !== epc[i] || bus.branch_taken !== ebt[i]) begin
        n_err++; $display("FAIL rel[%0d]: got pc=%h bt=%b want pc=%h bt=%b",
          i, bus.program_counter_out, bus.branch_taken, epc[i], ebt[i]);
      end
    end
    goto_addr(32'hFFFF_FFFC);
    drive(1'b1, 1'b0, COND_AL, BR_ABS, 32'h0);
    tick();
    n_vec++;
    if (bus.program_counter_out !== 32'h0) begin
      n_err++; $display("FAIL pc_wrap: got %h want %h", bus.program_counter_out, 32'h0);
    end
  endtask

  task automatic test_ras();
    logic [31:0] ret_pc [5] = '{32'h54, 32'h44, 32'h34, 32'h24, 32'h28};
    logic [31:0] exp_pc;
    logic [3:0]  got, want;
    goto_addr(32'h10);
    for (int i = 0; i < 5; i++) begin
      exp_pc = 32'h20 + 32'(i * 16);
      drive(1'b1, 1'b1, COND_AL, BR_CALL, exp_pc);
      tick();
      got  = {bus.branch_taken, bus.ras_empty, bus.ras_overflow, bus.ras_underflow};
      want = {1'b1, !RAS, RAS && (i == 4), 1'b0};
      n_vec++;
      if (bus.program_counter_out !== exp_pc || got !== want) begin
        n_err++; $display("FAIL call[%0d]: got pc=%h st=%b want pc=%h st=%b",
          i, bus.program_counter_out, got, exp_pc, want);
      end
    end
    for (int i = 0; i < 5; i++) begin
      exp_pc = RAS ? ret_pc[i] : 32'h64 + 32'(i * 4);
      drive(1'b1, 1'b1, COND_AL, BR_RET, 32'h0);
      tick();
      got  = {bus.branch_taken, bus.ras_empty, bus.ras_overflow, bus.ras_underflow};
      want = {RAS && (i < 4), !RAS || (i >= 3), RAS, RAS && (i == 4)};
      n_vec++;
      if (bus.program_counter_out !== exp_pc || got !== want) begin
        n_err++; $display("FAIL ret[%0d]: got pc=%h st=%b want pc=%h st=%b",
          i, bus.program_counter_out, got, exp_pc, want);
      end
    end
    drive(1'b1, 1'b0, COND_AL, BR_ABS, 32'h0);
    tick();
    n_vec++;
    if (bus.ras_underflow !== 1'b0 || bus.ras_overflow !== RAS) begin
      n_err++; $display("FAIL ras_pulse_end: got unf=%b ovf=%b want unf=0 ovf=%b",
        bus.ras_underflow, bus.ras_overflow, RAS);
    end
  endtask

  task automatic test_stall();
    goto_addr(32'h100);
    set_flags(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, COND_AL, BR_CALL, 32'h500);
    tick();
    tick();
    n_vec++;
    if (bus.program_counter_out !== 32'h100 || bus.branch_taken !== 1'b0 || bus.ras_empty !== 1'b1) begin
      n_err++; $display("FAIL stall: got pc=%h bt=%b empty=%b want pc=%h bt=0 empty=1",
        bus.program_counter_out, bus.branch_taken, bus.ras_empty, 32'h100);
    end
    set_flags(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, COND_EQ, BR_ABS, 32'h180);
    tick();
    n_vec++;
    if (bus.program_counter_out !== 32'h180) begin
      n_err++; $display("FAIL stall_flag_load: got %h want %h", bus.program_counter_out, 32'h180);
    end
    drive(1'b1, 1'b1, COND_AL, BR_CALL, 32'h300);
    tick();
    n_vec++;
    if (bus.program_counter_out !== 32'h300 || bus.ras_empty !== !RAS) begin
      n_err++; $display("FAIL call_after_stall: got pc=%h empty=%b want pc=%h empty=%b",
        bus.program_counter_out, bus.ras_empty, 32'h300, !RAS);
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b0, COND_AL, BR_ABS, 32'h0);
    #3 reset = 1'b1;
    #1;
    n_vec++;
    if ({bus.program_counter_out, bus.branch_taken, bus.ras_empty, bus.ras_overflow} !== {32'h0, 3'b010}) begin
      n_err++; $display("FAIL async_reset: got pc=%h bt=%b empty=%b ovf=%b want pc=0 bt=0 empty=1 ovf=0",
        bus.program_counter_out, bus.branch_taken, bus.ras_empty, bus.ras_overflow);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    drive(1'b1, 1'b1, COND_AL, BR_RET, 32'h0);
    tick();
    n_vec++;
    if (bus.program_counter_out !== 32'h4 || bus.branch_taken !== 1'b0 || bus.ras_underflow !== RAS) begin
      n_err++; $display("FAIL ret_after_reset: got pc=%h bt=%b unf=%b want pc=%h bt=0 unf=%b",
        bus.program_counter_out, bus.branch_taken, bus.ras_underflow, 32'h4, RAS);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_condition();
    test_bypass();
    test_relative();
    test_ras();
    test_stall();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/branch_unit.md
# branch_unit

Parametrised branch and program-counter unit for the single-cycle CPU. It owns the PC register and a 4-bit flag register (Z/S/C/V), and evaluates a 16-code branch condition. It supports absolute, PC-relative, call and return transfers; call and return use an optional return-address stack. It sits between the ALU (flag source), the control unit (FlagControl, BranchControl, mode) and instruction memory (PC consumer).

## Interface
- ADDR_W, 32, PC/target width
- PC_STEP, 4, sequential PC increment
- RESET_PC, 0, PC value after reset
- RAS_DEPTH, 4, return-stack entries (power of two, ≥2)
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- pc_en  in  1  advance PC this cycle; 0 = stall
- jump_addr  in  ADDR_W  absolute target (abs/call) or signed displacement (rel)
- zero_flag, sign_flag, carry_flag, overflow_flag  in  1 each  ALU flags
- flag_we  in  1  load flag register
- FlagControl  in  4  condition code
- BranchControl  in  1  branch request
- branch_mode  in  2  00 abs, 01 rel, 10 call, 11 ret
- program_counter_out  out  ADDR_W  registered PC
- branch_taken  out  1  registered; high for the cycle after a taken transfer
- ras_empty  out  1  return stack empty
- ras_overflow  out  1  sticky; a push overwrote the oldest entry
- ras_underflow  out  1  one-cycle pulse; a return was attempted with the stack empty

## Operation
- Effective flags: the incoming flags when flag_we=1 (same-cycle bypass); otherwise the flag register.
- Condition codes:
  - 0 always; 1 Z; 2 !Z; 3 C; 4 !C; 5 S; 6 !S; 7 V; 8 !V
  - 9 C&!Z; 10 !C|Z; 11 S==V; 12 S!=V; 13 !Z&(S==V); 14 Z|(S!=V); 15 never
- take = pc_en & BranchControl & cond.
- seq = PC + PC_STEP, computed modulo 2^ADDR_W.
- Next PC:
  - abs: jump_addr if take, else seq.
  - rel: seq + jump_addr (two's complement, wraps) if take, else seq.
  - call: jump_addr if take, and push seq.
  - ret: popped entry if take and the stack is non-empty. If take and the stack is empty: seq, and ras_underflow pulses.
- pc_en=0: PC, RAS and branch_taken are all held/cleared (branch_taken=0). flag_we still loads the flag register.
- Return stack:
  - Circular buffer with a top pointer and a count.
  - Push when full: the oldest entry is overwritten, count stays at RAS_DEPTH, and ras_overflow is set until reset.
  - At most one push or pop per cycle, since the mode is exclusive.
- branch_taken is asserted only when the transfer actually redirects the PC. An empty-stack return does not count.

## Timing
- Reset (asynchronous) values:
  - program_counter_out=RESET_PC
  - flag register = 0
  - branch_taken=0
  - RAS count 0, ras_empty=1
  - ras_overflow=0, ras_underflow=0
- Reset asserted mid-operation discards all stack contents immediately.
- Latency: one cycle. The next PC, branch_taken, RAS state and flag-register load all update on the same rising edge.
- ras_empty reflects the registered count, so it updates one cycle after a push or pop.
- ras_underflow is registered and is high for exactly one cycle.

## Configuration
- BRANCH_RAS_EN defined: return stack, ras_overflow and ras_underflow are built as described.
- BRANCH_RAS_EN undefined:
  - No stack storage.
  - call behaves as abs with no push.
  - ret is never taken: PC=seq, branch_taken=0.
  - ras_empty is tied to 1; ras_overflow and ras_underflow are tied to 0.

## Structure
- branch_pkg holds:
  - condition-code constants (COND_AL … COND_NV)
  - branch_mode encodings (BR_ABS, BR_REL, BR_CALL, BR_RET)
  - the flag-vector bit indices
- One sub-module, return_stack: parametrised by ADDR_W and RAS_DEPTH, with push, pop, data in/out, empty and overflow ports. It is instantiated only under BRANCH_RAS_EN.

## Test plan
- Reset → PC=RESET_PC(0), branch_taken=0, ras_empty=1. Then pc_en=1 with BranchControl=0 for 3 cycles → PC 4, 8, 12.
- Flags S=1 V=1, FlagControl=12 (LT), abs jump_addr=40 → not taken, PC=seq. FlagControl=11 (GE) → PC=40, branch_taken=1 for one cycle.
- Bypass: flag register Z=0, same cycle flag_we=1 with Z=1, FlagControl=1, abs 0x100 → PC=0x100.
- rel from PC=0x20 with jump_addr=-8 (0xFFFFFFF8), cond always → PC=0x1C. PC=0xFFFFFFFC sequential → PC=0 (wrap).
- RAS_DEPTH=4: five calls from PCs 0x10, 0x20, 0x30, 0x40, 0x50 → ras_overflow=1. Five returns → 0x54, 0x44, 0x34, 0x24, then the fifth falls through with a ras_underflow pulse and branch_taken=0.
- Stall: pc_en=0 during a taken call → PC unchanged, no push. Reset asserted between calls → ras_empty=1 and PC=RESET_PC without a clock edge.
